// File: rtl/cga_composite_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : cga_composite_encoder
//  Description : NTSC composite encoder for the CGA video path. Takes IRGB
//                pixels and CRTC hsync/vsync, regenerates horizontal and
//                vertical sync, adds colour burst, and produces a registered
//                DAC-width composite sample plus a 1-bit first-order
//                sigma-delta rendition of that sample.
//  Ports       : clk         master clock, 2**PHASE_BITS x 3.579545 MHz
//                reset       asynchronous, active-high
//                pix_en      14.318 MHz pixel strobe, one clk wide
//                video       IRGB pixel {I,R,G,B}
//                hsync       CRTC horizontal sync, active high
//                vsync       CRTC vertical sync, active high
//                bw_mode     1 = colour killed (no chroma, no burst)
//                hsync_out   regenerated horizontal sync, active high
//                vsync_out   regenerated vertical sync, active high
//                csync_out   composite sync, active low
//                comp_video  composite sample, OUT_W bits, registered
//                pdm_out     sigma-delta bitstream of comp_video
//  Revision    : 1.0  initial release
// ============================================================================
module cga_composite_encoder #(
    parameter int PHASE_BITS  = 3,
    parameter int OUT_W       = 7,
    parameter int HS_START    = 2,
    parameter int HS_END      = 6,
    parameter int BURST_START = 7,
    parameter int BURST_LEN   = 2,
    parameter int HS_MAX      = 11,
    parameter int VS_LINES    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    input  logic [3:0]       video,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             bw_mode,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             csync_out,
    output logic [OUT_W-1:0] comp_video,
    output logic             pdm_out
);

    // Pixel-count comparisons are done one bit wider than the 4-bit counter
    // so that window ends such as BURST_START+BURST_LEN cannot wrap.
    localparam logic [4:0] c_HS_START    = 5'(HS_START);
    localparam logic [4:0] c_HS_END      = 5'(HS_END);
    localparam logic [4:0] c_BURST_START = 5'(BURST_START);
    localparam logic [4:0] c_BURST_END   = 5'(BURST_START + BURST_LEN);
    localparam logic [3:0] c_HS_MAX      = 4'(HS_MAX);
    localparam logic [4:0] c_VS_LINES    = 5'(VS_LINES);
    localparam int         c_SHIFT       = OUT_W - 7;
    localparam int         c_OCT_SH      = PHASE_BITS - 3;

    // Subcarrier phase offsets of each hue, in eighths of a period.
    localparam logic [2:0] c_OFF_YELLOW  = 3'd0;
    localparam logic [2:0] c_OFF_RED     = 3'd2;
    localparam logic [2:0] c_OFF_MAGENTA = 3'd3;
    localparam logic [2:0] c_OFF_BLUE    = 3'd4;
    localparam logic [2:0] c_OFF_CYAN    = 3'd6;
    localparam logic [2:0] c_OFF_GREEN   = 3'd7;

    logic [3:0]            r_vid;
    logic                  r_hs_q;
    logic                  r_vs_q;
    logic [3:0]            r_hcnt;
    logic [3:0]            r_vcnt;
    logic [PHASE_BITS-1:0] r_ph;
    logic [OUT_W-1:0]      r_comp;
    logic [OUT_W:0]        r_acc;
    logic                  r_pdm;

    logic [3:0]            w_hcnt_next;
    logic [3:0]            w_vcnt_next;
    logic                  w_line_tick;
    logic                  w_hs;
    logic                  w_vs;
    logic                  w_cs;
    logic                  w_burst;
    logic [2:0]            w_sel;
    logic                  w_chroma;
    logic [6:0]            w_luma;
    logic [6:0]            w_level;
    logic [OUT_W-1:0]      w_level_out;
    logic [OUT_W:0]        w_pdm_sum;

    // A colour is lit for the half period that starts at its phase offset.
    // The subtraction wraps modulo 2**PHASE_BITS, so the MSB of the
    // difference tells which half of the period we are in.
    function automatic logic colour_on(input logic [PHASE_BITS-1:0] ph,
                                       input logic [2:0]            eighths);
        logic [PHASE_BITS-1:0] d;
        d = ph - (PHASE_BITS'(eighths) << c_OCT_SH);
        return ~d[PHASE_BITS-1];
    endfunction

    // ------------------------------------------------------------------
    // Horizontal / vertical counters
    // ------------------------------------------------------------------
    // A low registered hsync holds the counter at zero, which also handles
    // an hsync that ends early: the count restarts at the next strobe.
    assign w_hcnt_next = (!r_hs_q || r_hcnt == c_HS_MAX) ? 4'd0 : r_hcnt + 4'd1;

    // One tick per line, at the step onto HS_START.
    assign w_line_tick = (({1'b0, r_hcnt} + 5'd1) == c_HS_START) &&
                         ({1'b0, w_hcnt_next} == c_HS_START);

    always_comb begin
        w_vcnt_next = r_vcnt;
        if (!r_vs_q) begin
            w_vcnt_next = 4'd0;
        end else if (w_line_tick && r_vcnt != 4'hF) begin
            w_vcnt_next = r_vcnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vid  <= 4'd0;
            r_hs_q <= 1'b0;
            r_vs_q <= 1'b0;
            r_hcnt <= 4'd0;
            r_vcnt <= 4'd0;
        end else if (pix_en) begin
            r_vid  <= video;
            r_hs_q <= hsync;
            r_vs_q <= vsync;
            r_hcnt <= w_hcnt_next;
            r_vcnt <= w_vcnt_next;
        end
    end

    assign w_hs = ({1'b0, r_hcnt} >= c_HS_START) && ({1'b0, r_hcnt} < c_HS_END);
    assign w_vs = (r_vcnt != 4'd0) && ({1'b0, r_vcnt} <= c_VS_LINES);
    assign w_cs = ~(w_hs ^ w_vs);

    assign w_burst = ~bw_mode & ~r_vs_q &
                     ({1'b0, r_hcnt} >= c_BURST_START) &&
                     ({1'b0, r_hcnt} < c_BURST_END);

    // ------------------------------------------------------------------
    // Subcarrier phase and chroma
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ph <= '0;
        end else begin
            r_ph <= r_ph + PHASE_BITS'(1);
        end
    end

    // Burst flips R and G, turning black into yellow for the reference hue.
    assign w_sel = {r_vid[2] ^ w_burst, r_vid[1] ^ w_burst, r_vid[0]};

    always_comb begin
        w_chroma = 1'b0;
        if (bw_mode) begin
            w_chroma = |r_vid[2:0];
        end else begin
            case (w_sel)
                3'd0:    w_chroma = 1'b0;
                3'd1:    w_chroma = colour_on(r_ph, c_OFF_BLUE);
                3'd2:    w_chroma = colour_on(r_ph, c_OFF_GREEN);
                3'd3:    w_chroma = colour_on(r_ph, c_OFF_CYAN);
                3'd4:    w_chroma = colour_on(r_ph, c_OFF_RED);
                3'd5:    w_chroma = colour_on(r_ph, c_OFF_MAGENTA);
                3'd6:    w_chroma = colour_on(r_ph, c_OFF_YELLOW);
                default: w_chroma = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Luma and composite level
    // ------------------------------------------------------------------
    always_comb begin
        w_luma = 7'd29;
        case (r_vid[2:0])
            3'd0:    w_luma = 7'd29;
            3'd1:    w_luma = 7'd36;
            3'd2:    w_luma = 7'd49;
            3'd3:    w_luma = 7'd56;
            3'd4:    w_luma = 7'd39;
            3'd5:    w_luma = 7'd46;
            3'd6:    w_luma = 7'd60;
            default: w_luma = 7'd68;
        endcase
    end

    // Worst case 68+31+28 = 127, so the 7-bit sum never overflows.
    assign w_level     = w_luma + (r_vid[3] ? 7'd31 : 7'd0) + (w_chroma ? 7'd28 : 7'd0);
    assign w_level_out = OUT_W'(w_level) << c_SHIFT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_comp <= '0;
        end else begin
            r_comp <= w_cs ? w_level_out : '0;
        end
    end

    // ------------------------------------------------------------------
    // First-order sigma-delta: the carry out of the accumulator is the
    // output bit, so its mean density equals comp_video / 2**OUT_W.
    // ------------------------------------------------------------------
    assign w_pdm_sum = {1'b0, r_acc[OUT_W-1:0]} + {1'b0, r_comp};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_pdm <= 1'b0;
        end else begin
            r_acc <= w_pdm_sum;
            r_pdm <= r_acc[OUT_W];
        end
    end

    assign hsync_out  = w_hs;
    assign vsync_out  = w_vs;
    assign csync_out  = w_cs;
    assign comp_video = r_comp;
    assign pdm_out    = r_pdm;

endmodule
`default_nettype wire

// File: tb/tb_cga_composite_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cga_composite_encoder
//  Description : Self-checking bench for cga_composite_encoder. Two instances
//                share all inputs: default parameters, and PHASE_BITS=4 /
//                OUT_W=10. A behavioural model tracks pixel counts and line
//                counts as integers and derives the composite level from the
//                luma table, hue angles and sync rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cga_composite_encoder;

    localparam int HS_START    = 2;
    localparam int HS_END      = 6;
    localparam int BURST_START = 7;
    localparam int BURST_LEN   = 2;
    localparam int HS_MAX      = 11;
    localparam int VS_LINES    = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_en;
    logic [3:0] video;
    logic       hsync;
    logic       vsync;
    logic       bw_mode;

    logic [1:0] hs_o, vs_o, cs_o, pdm_o;
    logic [6:0] comp0;
    logic [9:0] comp1;

    always #5 clk = ~clk;

    cga_composite_encoder u_dut0 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .video(video),
        .hsync(hsync), .vsync(vsync), .bw_mode(bw_mode),
        .hsync_out(hs_o[0]), .vsync_out(vs_o[0]), .csync_out(cs_o[0]),
        .comp_video(comp0), .pdm_out(pdm_o[0])
    );

    cga_composite_encoder #(.PHASE_BITS(4), .OUT_W(10)) u_dut1 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .video(video),
        .hsync(hsync), .vsync(vsync), .bw_mode(bw_mode),
        .hsync_out(hs_o[1]), .vsync_out(vs_o[1]), .csync_out(cs_o[1]),
        .comp_video(comp1), .pdm_out(pdm_o[1])
    );

    // Luma by RGB code; hue angle in eighths of a subcarrier period per RGB
    // code (-1 = no chroma, 8 = chroma always on).
    int luma_tab [8] = '{29, 36, 49, 56, 39, 46, 60, 68};
    int hue_tab  [8] = '{-1, 4, 7, 6, 2, 3, 0, 8};

    int         m_hcnt, m_vcnt, cyc;
    bit         m_hsq, m_vsq;
    logic [3:0] m_vid;
    int         m_comp [2];
    int         n_vec = 0;
    int         n_err = 0;

    function automatic bit model_hs();
        return (m_hcnt >= HS_START) && (m_hcnt < HS_END);
    endfunction

    function automatic bit model_vs();
        return (m_vcnt >= 1) && (m_vcnt <= VS_LINES);
    endfunction

    function automatic logic [5:0] model_sync();
        bit h, v;
        h = model_hs();
        v = model_vs();
        return {{2{h}}, {2{v}}, {2{~(h ^ v)}}};
    endfunction

    function automatic int model_level(input int inst, input bit bw);
        int n, ph, hue, rgb;
        bit burst, chroma;
        n  = (inst == 0) ? 8 : 16;
        ph = cyc % n;
        if (model_hs() != model_vs()) return 0;
        burst = !bw && !m_vsq && m_hcnt >= BURST_START && m_hcnt < BURST_START + BURST_LEN;
        rgb   = int'(m_vid[2:0]);
        if (bw) begin
            chroma = (rgb != 0);
        end else begin
            hue = hue_tab[burst ? (rgb ^ 6) : rgb];
            if (hue < 0)       chroma = 1'b0;
            else if (hue == 8) chroma = 1'b1;
            else               chroma = ((ph - hue * n / 8 + n) % n) < (n / 2);
        end
        return (luma_tab[rgb] + (m_vid[3] ? 31 : 0) + (chroma ? 28 : 0)) * ((inst == 0) ? 1 : 8);
    endfunction

    task automatic model_reset();
        m_hcnt = 0; m_vcnt = 0; cyc = 0;
        m_hsq = 1'b0; m_vsq = 1'b0; m_vid = 4'd0;
        m_comp[0] = 0; m_comp[1] = 0;
    endtask

    // Drive one clock of stimulus, advance the model across the edge, and
    // return 1 time unit after the edge.
    task automatic cycle(input logic [3:0] v, input bit h, input bit vs_i,
                         input bit pe, input bit bw);
        int nh;
        video = v; hsync = h; vsync = vs_i; pix_en = pe; bw_mode = bw;
        @(posedge clk);
        m_comp[0] = model_level(0, bw);
        m_comp[1] = model_level(1, bw);
        if (pe) begin
            nh = (!m_hsq || m_hcnt == HS_MAX) ? 0 : m_hcnt + 1;
            if (!m_vsq)
                m_vcnt = 0;
            else if (m_hcnt == HS_START - 1 && nh == HS_START && m_vcnt < 15)
                m_vcnt = m_vcnt + 1;
            m_hcnt = nh;
            m_vid  = v;
            m_hsq  = h;
            m_vsq  = vs_i;
        end
        cyc = cyc + 1;
        #1;
    endtask

    task automatic test_reset();
        int ones0, ones1;
        reset = 1'b0; pix_en = 1'b0; video = 4'd0;
        hsync = 1'b0; vsync = 1'b0; bw_mode = 1'b0;
        #1 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if ({hs_o, vs_o, cs_o, pdm_o} !== 8'b00_00_11_00) begin
                n_err++;
                $display("FAIL reset_flags got %b expected %b", {hs_o, vs_o, cs_o, pdm_o}, 8'b00_00_11_00);
            end
            n_vec++;
            if (comp0 !== 7'd0 || comp1 !== 10'd0) begin
                n_err++;
                $display("FAIL reset_comp got %0d/%0d expected 0/0", comp0, comp1);
            end
            @(posedge clk);
        end
        #2 reset = 1'b0;
        model_reset();
        ones0 = 0; ones1 = 0;
        for (int k = 0; k < 1024; k++) begin
            cycle(4'd0, 1'b0, 1'b0, (k % 2) == 0, 1'b0);
            ones0 += int'(pdm_o[0]);
            ones1 += int'(pdm_o[1]);
            n_vec++;
            if (comp0 !== 7'(m_comp[0]) || comp1 !== 10'(m_comp[1]) || cs_o !== 2'b11) begin
                n_err++;
                $display("FAIL idle_black comp %0d/%0d cs %b expected %0d/%0d cs 11",
                         comp0, comp1, cs_o, m_comp[0], m_comp[1]);
            end
        end
        n_vec++;
        if (ones0 < 224 || ones0 > 240 || ones1 < 224 || ones1 > 240) begin
            n_err++;
            $display("FAIL pdm_duty ones %0d/%0d per 1024 expected 232 +/- 8", ones0, ones1);
        end
    endtask

    task automatic test_hsync_line();
        int hs_clks;
        for (int line = 0; line < 3; line++) begin
            hs_clks = 0;
            for (int k = 0; k < 48; k++) begin
                cycle(4'($urandom), k < 24, 1'b0, (k % 2) == 0, 1'b0);
                hs_clks += int'(hs_o[0]);
                n_vec++;
                if ({hs_o, vs_o, cs_o} !== model_sync()) begin
                    n_err++;
                    $display("FAIL hsync_line sync got %b expected %b", {hs_o, vs_o, cs_o}, model_sync());
                end
                n_vec++;
                if (comp0 !== 7'(m_comp[0]) || comp1 !== 10'(m_comp[1])) begin
                    n_err++;
                    $display("FAIL hsync_line comp got %0d/%0d expected %0d/%0d",
                             comp0, comp1, m_comp[0], m_comp[1]);
                end
            end
            n_vec++;
            if (hs_clks != (HS_END - HS_START) * 2) begin
                n_err++;
                $display("FAIL hsync_width got %0d clk expected %0d", hs_clks, (HS_END - HS_START) * 2);
            end
        end
    endtask

    task automatic test_burst_phase();
        int bursts;
        bursts = 0;
        for (int k = 0; k < 24 * 8; k++) begin
            cycle(4'd0, 1'b1, 1'b0, (k % 2) == 0, 1'b0);
            if (comp0 == 7'd57) bursts++;
            n_vec++;
            if (comp0 !== 7'(m_comp[0]) || comp1 !== 10'(m_comp[1])) begin
                n_err++;
                $display("FAIL burst_phase comp got %0d/%0d expected %0d/%0d",
                         comp0, comp1, m_comp[0], m_comp[1]);
            end
        end
        n_vec++;
        if (bursts == 0) begin
            n_err++;
            $display("FAIL burst_present got %0d burst-high samples expected >0", bursts);
        end
    endtask

    task automatic test_vsync();
        int vs_clks;
        vs_clks = 0;
        for (int k = 0; k < 24 * 9; k++) begin
            cycle(4'($urandom), 1'b1, k < 120, (k % 2) == 0, 1'b0);
            vs_clks += int'(vs_o[0]);
            n_vec++;
            if ({hs_o, vs_o, cs_o} !== model_sync()) begin
                n_err++;
                $display("FAIL vsync sync got %b expected %b", {hs_o, vs_o, cs_o}, model_sync());
            end
            n_vec++;
            if (comp0 !== 7'(m_comp[0]) || comp1 !== 10'(m_comp[1])) begin
                n_err++;
                $display("FAIL vsync comp got %0d/%0d expected %0d/%0d",
                         comp0, comp1, m_comp[0], m_comp[1]);
            end
        end
        n_vec++;
        if (vs_clks != VS_LINES * (HS_MAX + 1) * 2) begin
            n_err++;
            $display("FAIL vsync_width got %0d clk expected %0d", vs_clks, VS_LINES * (HS_MAX + 1) * 2);
        end
    endtask

    task automatic test_bw_mode();
        for (int k = 0; k < 64; k++) begin
            cycle(4'b1110, 1'b0, 1'b0, (k % 2) == 0, 1'b1);
            if (k >= 2) begin
                n_vec++;
                if (comp0 !== 7'd119 || comp1 !== 10'd952) begin
                    n_err++;
                    $display("FAIL bw_white comp got %0d/%0d expected 119/952", comp0, comp1);
                end
            end
        end
    endtask

    task automatic test_red_phase();
        int p, e0, e1;
        for (int k = 0; k < 64; k++) begin
            cycle(4'b0100, 1'b0, 1'b0, (k % 2) == 0, 1'b0);
            if (k >= 2) begin
                p  = (cyc - 1) % 16;
                e1 = ((p >= 4 && p <= 11) ? 67 : 39) * 8;
                p  = (cyc - 1) % 8;
                e0 = (p >= 2 && p <= 5) ? 67 : 39;
                n_vec++;
                if (comp0 !== 7'(e0) || comp1 !== 10'(e1)) begin
                    n_err++;
                    $display("FAIL red_phase comp got %0d/%0d expected %0d/%0d", comp0, comp1, e0, e1);
                end
            end
        end
    endtask

    task automatic test_random();
        bit h, v, bw;
        h = 1'b1; v = 1'b0; bw = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 39) == 0)  h  = ~h;
            if ($urandom_range(0, 299) == 0) v  = ~v;
            if ($urandom_range(0, 499) == 0) bw = ~bw;
            cycle(4'($urandom), h, v, $urandom_range(0, 1) == 1, bw);
            n_vec++;
            if ({hs_o, vs_o, cs_o} !== model_sync()) begin
                n_err++;
                $display("FAIL random sync got %b expected %b at cyc %0d", {hs_o, vs_o, cs_o}, model_sync(), cyc);
            end
            n_vec++;
            if (comp0 !== 7'(m_comp[0]) || comp1 !== 10'(m_comp[1])) begin
                n_err++;
                $display("FAIL random comp got %0d/%0d expected %0d/%0d at cyc %0d",
                         comp0, comp1, m_comp[0], m_comp[1], cyc);
            end
        end
    endtask

    task automatic test_reset_midline();
        for (int k = 0; k < 38; k++)
            cycle(4'($urandom), 1'b1, 1'b0, (k % 2) == 0, 1'b0);
        reset = 1'b1;
        #1;
        n_vec++;
        if ({hs_o, vs_o, cs_o, pdm_o} !== 8'b00_00_11_00 || comp0 !== 7'd0 || comp1 !== 10'd0) begin
            n_err++;
            $display("FAIL midline_reset flags %b comp %0d/%0d expected 00001100 0/0",
                     {hs_o, vs_o, cs_o, pdm_o}, comp0, comp1);
        end
        @(posedge clk);
        #4 reset = 1'b0;
        model_reset();
        for (int k = 0; k < 72; k++) begin
            cycle(4'd0, 1'b1, 1'b0, (k % 2) == 0, 1'b0);
            n_vec++;
            if (comp0 !== 7'(m_comp[0]) || comp1 !== 10'(m_comp[1]) || {hs_o, vs_o, cs_o} !== model_sync()) begin
                n_err++;
                $display("FAIL after_reset comp %0d/%0d sync %b expected %0d/%0d sync %b",
                         comp0, comp1, {hs_o, vs_o, cs_o}, m_comp[0], m_comp[1], model_sync());
            end
        end
    endtask

    initial begin
        test_reset();
        test_hsync_line();
        test_burst_phase();
        test_vsync();
        test_bw_mode();
        test_red_phase();
        test_random();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
